// File: rtl/sl_pkg.sv
// Shared types and helpers for the serial-line receive controller.
package sl_pkg;

  typedef enum logic [1:0] {
    SL_MODE_8   = 2'd0,
    SL_MODE_16  = 2'd1,
    SL_MODE_32  = 2'd2,
    SL_MODE_BAD = 2'd3
  } sl_mode_e;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_ARM = 2'd1,
    SL_RUN = 2'd2
  } sl_state_e;

  // Word length in bits for a receiver mode; 0 for the invalid encoding.
  function automatic logic [5:0] sl_width(input sl_mode_e mode);
    case (mode)
      SL_MODE_8:  sl_width = 6'd8;
      SL_MODE_16: sl_width = 6'd16;
      SL_MODE_32: sl_width = 6'd32;
      default:    sl_width = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/sl_rx_fifo.sv
// Circular word buffer with occupancy count. A pop on an empty buffer is
// ignored; a push on a full buffer only lands when a pop frees a slot in
// the same cycle.
module sl_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because the head is only
  // presented while the count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sl_rx_ctrl.sv
// Serial-line receive controller: sequences the receiver reset/mode,
// synchronises its completion flags, right-aligns finished words into a
// FIFO and keeps error/overflow status.
// Optional build macro SL_RX_CTRL_PARITY_KEEP_EN: bad words are also
// queued, tagged with out_err, instead of being dropped.
module sl_rx_ctrl
  import sl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_en,
  input  logic [1:0]  cfg_mode,
  input  logic        clr,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic        rx_ready,
  output logic [1:0]  rx_mode,
  output logic        rx_reset,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ack,
  output logic [7:0]  err_cnt,
  output logic        overflow,
  output logic        cfg_err,
  output logic        busy
);

`ifdef SL_RX_CTRL_PARITY_KEEP_EN
  localparam int EW = 33;
`else
  localparam int EW = 32;
`endif

  sl_state_e state;
  sl_state_e next_state;
  sl_mode_e  mode_q;
  sl_mode_e  cfg_mode_e;
  logic      arm_cnt;

  logic rdy_s1, rdy_s2, rdy_s3;
  logic vld_s1, vld_s2;
  logic word_evt;
  logic evt_q;
  logic good_q;
  logic [31:0] word_q;

  logic                      fifo_push;
  logic [EW-1:0]             fifo_wdata;
  logic [EW-1:0]             fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      drop;

  assign cfg_mode_e = sl_mode_e'(cfg_mode);
  assign cfg_err    = cfg_en && (cfg_mode_e == SL_MODE_BAD);
  assign rx_mode    = mode_q;

  // State register, arm-phase cycle counter and mode latch on entry to ARM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SL_OFF;
      arm_cnt <= 1'b0;
      mode_q  <= SL_MODE_8;
    end else begin
      state   <= next_state;
      arm_cnt <= (state == SL_ARM) ? ~arm_cnt : 1'b0;
      if (state != SL_ARM && next_state == SL_ARM) mode_q <= cfg_mode_e;
    end
  end

  // Next-state logic; an invalid mode in RUN shuts down rather than re-arming.
  always_comb begin
    next_state = state;
    case (state)
      SL_OFF: if (cfg_en && cfg_mode_e != SL_MODE_BAD) next_state = SL_ARM;
      SL_ARM: if (arm_cnt) next_state = SL_RUN;
      SL_RUN: begin
        if (!cfg_en || cfg_mode_e == SL_MODE_BAD) next_state = SL_OFF;
        else if (cfg_mode_e != mode_q)            next_state = SL_ARM;
      end
      default: next_state = SL_OFF;
    endcase
  end

  // Receiver held in reset everywhere except RUN.
  always_comb begin
    rx_reset = 1'b1;
    busy     = 1'b0;
    case (state)
      SL_ARM: busy = 1'b1;
      SL_RUN: begin
        rx_reset = 1'b0;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign word_evt = (state == SL_RUN) && (next_state == SL_RUN) && rdy_s2 && !rdy_s3;

  // Two-flop synchronisers, rise detect on ready, and one stage that holds
  // the aligned word so the FIFO write lands three edges after first sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_s1 <= 1'b0;
      rdy_s2 <= 1'b0;
      rdy_s3 <= 1'b0;
      vld_s1 <= 1'b0;
      vld_s2 <= 1'b0;
      evt_q  <= 1'b0;
      good_q <= 1'b0;
      word_q <= '0;
    end else begin
      rdy_s1 <= rx_ready;
      rdy_s2 <= rdy_s1;
      rdy_s3 <= rdy_s2;
      vld_s1 <= rx_valid;
      vld_s2 <= vld_s1;
      evt_q  <= word_evt;
      if (word_evt) begin
        good_q <= vld_s2;
        word_q <= rx_data >> (6'd32 - sl_width(mode_q));
      end
    end
  end

`ifdef SL_RX_CTRL_PARITY_KEEP_EN
  assign fifo_push  = evt_q;
  assign fifo_wdata = {~good_q, word_q};
  assign out_err    = fifo_empty ? 1'b0 : fifo_rdata[32];
`else
  assign fifo_push  = evt_q & good_q;
  assign fifo_wdata = word_q;
  assign out_err    = 1'b0;
`endif

  assign out_data  = fifo_empty ? 32'd0 : fifo_rdata[31:0];
  assign out_valid = (fifo_count != '0);
  assign drop      = fifo_push & fifo_full & ~out_ack;

  // Error counter saturates; clr wins over any same-cycle update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt  <= 8'd0;
      overflow <= 1'b0;
    end else if (clr) begin
      err_cnt  <= 8'd0;
      overflow <= 1'b0;
    end else begin
      if (evt_q && !good_q && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  sl_rx_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (out_ack),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_sl_rx_ctrl.sv
// Self-checking bench for sl_rx_ctrl with a queue-based reference model.
module tb_sl_rx_ctrl;

  localparam int DEPTH = 4;
`ifdef SL_RX_CTRL_PARITY_KEEP_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_en;
  logic [1:0]  cfg_mode;
  logic        clr;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [1:0]  rx_mode;
  logic        rx_reset;
  logic [31:0] out_data;
  logic        out_err;
  logic        out_valid;
  logic        out_ack;
  logic [7:0]  err_cnt;
  logic        overflow;
  logic        cfg_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  int          exp_err = 0;
  bit          exp_ovf = 1'b0;
  int          cur_w   = 8;

  always #5 clk = ~clk;

  sl_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .clr(clr),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_mode(rx_mode), .rx_reset(rx_reset), .out_data(out_data), .out_err(out_err),
    .out_valid(out_valid), .out_ack(out_ack), .err_cnt(err_cnt),
    .overflow(overflow), .cfg_err(cfg_err), .busy(busy)
  );

  // Keep the top w bits of the line register as an unsigned integer.
  function automatic logic [31:0] align(input logic [31:0] d, input int w);
    longint q = longint'(d) / (longint'(1) << (32 - w));
    return q[31:0];
  endfunction

  // Reference behaviour of one completed word, applied at the push edge.
  task automatic model_word(input logic [31:0] d, input logic v, input logic ack, input logic c);
    if (ack && exp_q.size() > 0) void'(exp_q.pop_front());
    if (v || KEEP) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({~v, align(d, cur_w)});
      else exp_ovf = 1'b1;
    end
    if (!v && exp_err < 255) exp_err++;
    if (c) begin
      exp_err = 0;
      exp_ovf = 1'b0;
    end
  endtask

  // Configure a mode and wait out the arm phase.
  task automatic arm(input logic [1:0] m);
    @(negedge clk);
    cfg_en   = 1'b1;
    cfg_mode = m;
    cur_w    = 8 << int'(m);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  // Deliver one word; ack/clr are applied on the cycle of the FIFO write.
  task automatic send_word(input logic [31:0] d, input logic v, input logic ack, input logic c);
    @(negedge clk);
    rx_data  = d;
    rx_valid = v;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    out_ack = ack;
    clr     = c;
    @(posedge clk);
    model_word(d, v, ack, c);
    @(negedge clk);
    out_ack  = 1'b0;
    clr      = 1'b0;
    rx_ready = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rx_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_rx_reset: got %b expected 1", rx_reset); end
    checks++; if (rx_mode !== 2'd0) begin errors++; $display("[TB] FAIL reset_rx_mode: got %0d expected 0", rx_mode); end
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_err !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_out: got v=%b d=%h e=%b expected 0/0/0", out_valid, out_data, out_err); end
    checks++; if (err_cnt !== 8'd0 || overflow !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_status: got cnt=%0d ovf=%b busy=%b expected 0/0/0", err_cnt, overflow, busy); end
    cfg_en = 1'b1; cfg_mode = 2'd3; #1;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL reset_cfg_err: got %b expected 1", cfg_err); end
    cfg_en = 1'b0; cfg_mode = 2'd0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mode8();
    arm(2'd0);
    checks++; if (rx_reset !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("[TB] FAIL arm_run: got rx_reset=%b busy=%b expected 0/1", rx_reset, busy); end
    @(negedge clk);
    rx_data = {8'hA5, 24'h3C5A96}; rx_valid = 1'b1; rx_ready = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (out_valid !== (e == 3)) begin errors++;
        $display("[TB] FAIL latency_edge%0d: got out_valid=%b expected %b", e, out_valid, e == 3); end
    end
    checks++; if (out_data !== 32'h000000A5 || err_cnt !== 8'd0) begin errors++;
      $display("[TB] FAIL mode8_word: got %h cnt=%0d expected 000000a5 cnt=0", out_data, err_cnt); end
    rx_ready = 1'b0; rx_valid = 1'b0; out_ack = 1'b1;
    @(negedge clk); out_ack = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mode8_pop: got %b expected 0", out_valid); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_bad_parity();
    arm(2'd1);
    send_word({16'h1234, 16'($urandom)}, 1'b0, 1'b0, 1'b0);
    checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("[TB] FAIL bad_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
    checks++; if (out_valid !== KEEP) begin errors++; $display("[TB] FAIL bad_out_valid: got %b expected %b", out_valid, KEEP); end
    while (exp_q.size() > 0) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0][31:0] || out_err !== exp_q[0][32]) begin errors++;
        $display("[TB] FAIL bad_head: got v=%b %h e=%b expected %h e=%b", out_valid, out_data, out_err, exp_q[0][31:0], exp_q[0][32]); end
      out_ack = 1'b1; @(negedge clk); out_ack = 1'b0; void'(exp_q.pop_front());
    end
  endtask

  task automatic test_mode_change();
    logic [31:0] d;
    arm(2'd1);
    @(negedge clk);
    rx_data = $urandom; rx_valid = 1'b1; rx_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    cfg_mode = 2'd2; cur_w = 32;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (rx_reset !== (e < 2)) begin errors++;
        $display("[TB] FAIL rearm_edge%0d: got rx_reset=%b expected %b", e, rx_reset, e < 2); end
    end
    checks++; if (rx_mode !== 2'd2) begin errors++; $display("[TB] FAIL rearm_mode: got %0d expected 2", rx_mode); end
    rx_ready = 1'b0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL partial_discard: got %b expected 0", out_valid); end
    d = $urandom;
    send_word(d, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== d) begin errors++;
      $display("[TB] FAIL word32: got v=%b %h expected %h", out_valid, out_data, d); end
    out_ack = 1'b1; @(negedge clk); out_ack = 1'b0; void'(exp_q.pop_front());
  endtask

  task automatic test_overflow();
    arm(2'd2);
    for (int i = 0; i < 5; i++) send_word($urandom, 1'b1, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1 || exp_ovf !== 1'b1) begin errors++;
      $display("[TB] FAIL overflow_set: got %b expected 1", overflow); end
    @(negedge clk); clr = 1'b1; @(negedge clk); clr = 1'b0; exp_ovf = 1'b0; exp_err = 0;
    send_word($urandom, 1'b1, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_push_pop: got overflow=%b expected 0", overflow); end
    while (exp_q.size() > 0) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0][31:0]) begin errors++;
        $display("[TB] FAIL fifo_order: got v=%b %h expected %h", out_valid, out_data, exp_q[0][31:0]); end
      out_ack = 1'b1; @(negedge clk); out_ack = 1'b0; void'(exp_q.pop_front());
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fifo_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_cfg_err_sat();
    @(negedge clk); cfg_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || rx_reset !== 1'b1) begin errors++;
      $display("[TB] FAIL disable: got busy=%b rx_reset=%b expected 0/1", busy, rx_reset); end
    cfg_en = 1'b1; cfg_mode = 2'd3;
    repeat (3) @(negedge clk);
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b0 || rx_reset !== 1'b1) begin errors++;
      $display("[TB] FAIL cfg_bad: got cfg_err=%b busy=%b rx_reset=%b expected 1/0/1", cfg_err, busy, rx_reset); end
    arm(2'd1);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL cfg_ok: got %b expected 0", cfg_err); end
    for (int i = 0; i < 256; i++) send_word($urandom, 1'b0, 1'b1, 1'b0);
    checks++; if (err_cnt !== 8'd255 || exp_err != 255) begin errors++; $display("[TB] FAIL err_saturate: got %0d expected 255", err_cnt); end
    @(negedge clk); clr = 1'b1; @(negedge clk); clr = 1'b0; exp_err = 0; exp_ovf = 1'b0;
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL err_clr: got %0d expected 0", err_cnt); end
    send_word($urandom, 1'b0, 1'b0, 1'b1);
    checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("[TB] FAIL clr_priority: got %0d expected %0d", err_cnt, exp_err); end
    while (exp_q.size() > 0) begin
      out_ack = 1'b1; @(negedge clk); out_ack = 1'b0; void'(exp_q.pop_front());
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic v, a;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) arm(2'($urandom_range(0, 2)));
      d = $urandom; v = ($urandom_range(0, 3) != 0); a = 1'($urandom_range(0, 1));
      send_word(d, v, a, 1'b0);
      checks++; if (err_cnt !== 8'(exp_err) || overflow !== exp_ovf) begin errors++;
        $display("[TB] FAIL rand_status%0d: got cnt=%0d ovf=%b expected %0d/%b", i, err_cnt, overflow, exp_err, exp_ovf); end
      checks++;
      if (exp_q.size() == 0) begin
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rand_empty%0d: got %b expected 0", i, out_valid); end
      end else if (out_valid !== 1'b1 || out_data !== exp_q[0][31:0] || out_err !== exp_q[0][32]) begin errors++;
        $display("[TB] FAIL rand_head%0d: got v=%b %h e=%b expected %h e=%b", i, out_valid, out_data, out_err, exp_q[0][31:0], exp_q[0][32]);
      end
    end
    while (exp_q.size() > 0) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0][31:0] || out_err !== exp_q[0][32]) begin errors++;
        $display("[TB] FAIL rand_drain: got v=%b %h expected %h", out_valid, out_data, exp_q[0][31:0]); end
      out_ack = 1'b1; @(negedge clk); out_ack = 1'b0; void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    arm(2'd0);
    send_word($urandom, 1'b1, 1'b0, 1'b0);
    send_word($urandom, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rx_data = $urandom; rx_valid = 1'b1; rx_ready = 1'b1;
    @(posedge clk); #2 reset = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || rx_reset !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_mid: got v=%b d=%h rx_reset=%b busy=%b expected 0/0/1/0", out_valid, out_data, rx_reset, busy); end
    checks++; if (err_cnt !== 8'd0 || overflow !== 1'b0 || rx_mode !== 2'd0) begin errors++;
      $display("[TB] FAIL reset_mid_status: got cnt=%0d ovf=%b mode=%0d expected 0/0/0", err_cnt, overflow, rx_mode); end
    @(negedge clk);
    rx_ready = 1'b0; rx_valid = 1'b0; reset = 1'b0;
    exp_q.delete(); exp_err = 0; exp_ovf = 1'b0;
    arm(2'd0);
    d = $urandom;
    send_word(d, 1'b1, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== {24'd0, d[31:24]}) begin errors++;
      $display("[TB] FAIL post_reset_word: got v=%b %h expected %h", out_valid, out_data, {24'd0, d[31:24]}); end
    out_ack = 1'b1; @(negedge clk); out_ack = 1'b0; void'(exp_q.pop_front());
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_empty: got %b expected 0", out_valid); end
  endtask

  initial begin
    reset = 1'b1; cfg_en = 1'b0; cfg_mode = 2'd0; clr = 1'b0;
    rx_data = 32'd0; rx_valid = 1'b0; rx_ready = 1'b0; out_ack = 1'b0;
    test_reset();
    test_mode8();
    test_bad_parity();
    test_mode_change();
    test_overflow();
    test_cfg_err_sat();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
